// File: rtl/capture_buffer.sv
// capture_buffer: sample store between the system controller and the
// firmware readout path. Accepts the controller's unthrottled sample stream,
// holds up to DEPTH samples and hands them out on a valid/ready stream.
// Also tracks fill level, high-water mark and a saturating count of samples
// lost to overflow. A synchronous clear empties the store between runs.
module capture_buffer #(
    parameter int DEPTH          = 1024,
    parameter int DATA_WIDTH     = 32,
    parameter int AFULL_THRESH   = DEPTH - 4,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_data_vld,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_data_vld,
    input  logic                      out_data_rdy,
    output logic [AW:0]               level,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [AW:0]               high_water,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic                      event_overflow
);

    localparam logic [AW:0]               LVL_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]               LVL_AFULL = (AW + 1)'(AFULL_THRESH);
    localparam logic [AW-1:0]             PTR_ONE   = AW'(1);
    localparam logic [AW:0]               LVL_ONE   = (AW + 1)'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE  = DROP_CNT_WIDTH'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX  = '1;

    // Sample storage; deliberately not reset, contents are only meaningful
    // between rd_ptr and wr_ptr.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               level_q, level_d;
    logic [AW:0]               high_water_q, high_water_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      event_overflow_q, event_overflow_d;

    logic full_w;
    logic empty_w;
    logic push;
    logic pop;
    logic drop;

    // Status flags decode from the registered level only; pointers never
    // distinguish full from empty.
    always_comb begin
        full_w  = (level_q == LVL_FULL);
        empty_w = (level_q == '0);
    end

    // Handshake qualification. A write while full is rejected even when a pop
    // frees a slot in the same cycle. Clear suppresses both transfers.
    always_comb begin
        push = in_data_vld & ~full_w & ~clr;
        pop  = ~empty_w & out_data_rdy & ~clr;
        drop = in_data_vld & full_w & ~clr;
    end

    // Next-state for pointers, level, high-water mark and overflow statistics.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        level_d          = level_q;
        high_water_d     = high_water_q;
        drop_cnt_d       = drop_cnt_q;
        event_overflow_d = 1'b0;

        if (clr) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            high_water_d = '0;
            drop_cnt_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase

            if (level_d > high_water_q) begin
                high_water_d = level_d;
            end

            if (drop) begin
                event_overflow_d = 1'b1;
                if (drop_cnt_q != DROP_MAX) begin
                    drop_cnt_d = drop_cnt_q + DROP_ONE;
                end
            end
        end
    end

    // Control and statistics registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            high_water_q     <= '0;
            drop_cnt_q       <= '0;
            event_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            high_water_q     <= high_water_d;
            drop_cnt_q       <= drop_cnt_d;
            event_overflow_q <= event_overflow_d;
        end
    end

    // Storage write; gated by reset so an in-reset write cannot land anywhere.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Output decode: the head sample is read combinationally and only moves
    // when rd_ptr advances, so it holds while the reader stalls.
    always_comb begin
        out_data       = mem[rd_ptr_q];
        out_data_vld   = ~empty_w;
        level          = level_q;
        full           = full_w;
        empty          = empty_w;
        almost_full    = (level_q >= LVL_AFULL);
        high_water     = high_water_q;
        drop_cnt       = drop_cnt_q;
        event_overflow = event_overflow_q;
    end

endmodule
